axil_cmd_initiator: RTL and testbench
=====================================

Name: axil_cmd_initiator

Overview:
AXI4-lite initiator (manager) that converts a simple single-outstanding command/response stream into AXI4-lite read/write transactions. It is the opposite end of the 64-bit AXI4-lite responder used by the FPGA sync register block. It is used by FPGA-side sequencers and benches to drive register blocks without hand-toggling channel valids. It adds per-transaction timeout detection so a hung responder never blocks the command source silently.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 64, AXI data width; strobe width is DATA_W/8
TIMEOUT_CYCLES, 1024, cycles from issue to completion before a timeout response; 0 disables timeout

Ports:
aclk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transaction address
cmd_prot  in  3  AxPROT value
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_resp  out  2  xRESP of the completed transaction
rsp_timeout  out  1  response was generated by timeout
awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_W/3  AW channel
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  W channel
bvalid/bready/bresp  in/out/in  1/1/2  B channel
arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_W/3  AR channel
rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  R channel

Behaviour:
- Reset (rstn = 0 at a rising aclk edge): state goes to IDLE. All valids, readies, rsp_valid, rsp_timeout and the abandoned flag are cleared; rsp_rdata and rsp_resp are cleared to 0. cmd_ready is 0 while rstn = 0. Reset mid-transaction abandons the transaction without a response.
- cmd_ready = rstn && state == IDLE (combinational). One transaction is outstanding at a time.
- States: IDLE, WR, RD, RSP, DRAIN.
- IDLE, accept at cycle N: address, prot, data and strobes are registered.
  - Write: awvalid, wvalid and bready are driven to 1 from N+1. State goes to WR.
  - Read: arvalid and rready are driven to 1 from N+1. State goes to RD.
- WR:
  - awvalid and wvalid drop independently on the cycle after their own handshake.
  - The AW and W handshakes may occur in either order or in the same cycle.
  - A B handshake (bvalid && bready) counts only after both AW and W are done. bresp is captured, bready drops, and state goes to RSP.
  - Minimum latency: rsp_valid is asserted at N+3.
- RD:
  - arvalid drops on the cycle after the AR handshake.
  - An R handshake captures rdata and rresp, rready drops, and state goes to RSP.
  - Minimum latency: rsp_valid is asserted at N+3.
- RSP: rsp_valid = 1 and all rsp_* outputs are held stable until rsp_ready. On the handshake, rsp_valid drops and state goes to IDLE, or to DRAIN if the abandoned flag is set and the AXI transaction is still open.
- Timeout:
  - The counter is cleared on accept and increments every cycle in WR or RD.
  - When the counter reaches TIMEOUT_CYCLES with no completion, the block emits a response with rsp_timeout = 1, rsp_resp = 2'b10 and rsp_rdata = 0, and sets the abandoned flag.
  - AXI valids and readies stay asserted; valids are never withdrawn before their handshake (AXI compliance).
  - The late B or R beat is discarded.
  - If completion and timeout occur in the same cycle, completion wins (rsp_timeout = 0).
  - The counter saturates and does not wrap.
- DRAIN: waits for the remaining AXI handshakes, discards the results, then goes to IDLE. cmd_ready stays 0 throughout.
- A beat with bvalid or rvalid but no outstanding request is ignored. bready and rready are 0 in IDLE, so the responder stalls.

Decomposition:
- Package axil_cmd_initiator_pkg:
  - state enum typedef
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10 constants
  - TIMEOUT counter width function: $clog2(TIMEOUT_CYCLES + 1)
- No sub-module; the channel-done tracking and timeout counter stay inline.

Test Plan:
- Write 0x10 / 0xDEADBEEF_CAFEF00D / strb 0xFF, responder with awready = wready = bvalid immediate -> AW and W handshake at N+1, rsp_valid at N+3, rsp_resp = 00, rsp_timeout = 0.
- Write with wready delayed 5 cycles after awready, bvalid = 1 early -> B not accepted before W completes; single response with resp = 00.
- Read 0x20, responder returns rdata = 0x0123_4567_89AB_CDEF, rresp = 10 -> rsp_rdata = 0x0123_4567_89AB_CDEF, rsp_resp = 10, one response; rsp_ready held low 3 cycles -> outputs stable.
- TIMEOUT_CYCLES = 8, arready never asserted -> timeout response 8 cycles after issue (resp = 10, rdata = 0, timeout = 1), arvalid still 1. Grant arready and return R later -> beat discarded, cmd_ready returns to 1 only after the R handshake.
- Completion on exactly the timeout cycle -> rsp_timeout = 0 and the real data is returned.
- rstn low for 1 cycle mid-WR -> all valids 0 next cycle, no response emitted, next command issues normally.

Source files
------------

// File: rtl/axil_cmd_initiator_pkg.sv
// Shared types and constants for the AXI4-lite command initiator.
package axil_cmd_initiator_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      RD    = 3'd2,
      RSP   = 3'd3,
      DRAIN = 3'd4
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // A timeout of 0 still needs a 1-bit counter to keep the declaration legal.
   function automatic int tmo_cnt_w(input int timeout_cycles);
      int w;
      w = $clog2(timeout_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axil_cmd_initiator.sv
// Single-outstanding command/response to AXI4-lite initiator with per-transaction timeout.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   WR    | AW/W in flight, waiting for B once both address and data are taken
//   RD    | AR in flight, waiting for R once the address is taken
//   RSP   | response presented, held until rsp_ready
//   DRAIN | timed-out transaction still open on AXI; retire its handshakes silently
module axil_cmd_initiator
   import axil_cmd_initiator_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                aclk,
   input  logic                rstn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [2:0]          cmd_prot,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [2:0]          awprot,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [2:0]          arprot,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp
);

   localparam int          CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
   localparam logic [31:0] TMO   = TIMEOUT_CYCLES;

   state_e                state_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [2:0]            prot_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic                  rsp_valid_q, rsp_timeout_q, abandoned_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic [1:0]            rsp_resp_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  b_hs, r_hs, tmo_hit, axi_open_nx;

   // A channel's valid is cleared the cycle after its handshake, so a low valid
   // while the ready is still up means that address/data phase has completed.
   assign b_hs    = bvalid && bready_q && !awvalid_q && !wvalid_q;
   assign r_hs    = rvalid && rready_q && !arvalid_q;
   assign tmo_hit = (TMO != 32'd0) && (32'(cnt_q) + 32'd1 == TMO);
   assign cnt_d   = (32'(cnt_q) < TMO) ? cnt_q + 1'b1 : cnt_q;

   assign axi_open_nx = (awvalid_q && !awready) || (wvalid_q && !wready) ||
                        (bready_q && !b_hs) || (arvalid_q && !arready) ||
                        (rready_q && !r_hs);

   always_ff @(posedge aclk) begin
      if (!rstn) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         prot_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= AXI_RESP_OKAY;
         abandoned_q   <= 1'b0;
         cnt_q         <= '0;
      end else begin
         // Channel retirement runs in every state so late beats after a timeout still complete.
         if (awvalid_q && awready) awvalid_q <= 1'b0;
         if (wvalid_q && wready)   wvalid_q  <= 1'b0;
         if (arvalid_q && arready) arvalid_q <= 1'b0;
         if (b_hs)                 bready_q  <= 1'b0;
         if (r_hs)                 rready_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q      <= cmd_addr;
                  prot_q      <= cmd_prot;
                  wdata_q     <= cmd_wdata;
                  wstrb_q     <= cmd_wstrb;
                  cnt_q       <= '0;
                  abandoned_q <= 1'b0;
                  if (cmd_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     bready_q  <= 1'b1;
                     state_q   <= WR;
                  end else begin
                     arvalid_q <= 1'b1;
                     rready_q  <= 1'b1;
                     state_q   <= RD;
                  end
               end
            end
            WR, RD: begin
               cnt_q <= cnt_d;
               if ((state_q == WR) ? b_hs : r_hs) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_timeout_q <= 1'b0;
                  rsp_resp_q    <= (state_q == WR) ? bresp : rresp;
                  rsp_rdata_q   <= (state_q == WR) ? '0 : rdata;
                  state_q       <= RSP;
               end else if (tmo_hit) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_resp_q    <= AXI_RESP_SLVERR;
                  rsp_rdata_q   <= '0;
                  abandoned_q   <= 1'b1;
                  state_q       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= (abandoned_q && axi_open_nx) ? DRAIN : IDLE;
               end
            end
            DRAIN: begin
               if (!axi_open_nx) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = rstn && (state_q == IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;
   assign awvalid     = awvalid_q;
   assign awaddr      = addr_q;
   assign awprot      = prot_q;
   assign wvalid      = wvalid_q;
   assign wdata       = wdata_q;
   assign wstrb       = wstrb_q;
   assign bready      = bready_q;
   assign arvalid     = arvalid_q;
   assign araddr      = addr_q;
   assign arprot      = prot_q;
   assign rready      = rready_q;

endmodule

// File: tb/tb_axil_cmd_initiator.sv
// Bench for axil_cmd_initiator: cycle-scripted responder, response scoreboard, TIMEOUT_CYCLES = 8.
module tb_axil_cmd_initiator;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;
   localparam int TMO    = 8;

   logic              aclk = 1'b0;
   logic              rstn;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_prot;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_wstrb;
   logic              rsp_valid, rsp_ready, rsp_timeout;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [2:0]        awprot, arprot;
   logic [DATA_W-1:0] wdata, rdata;
   logic [STRB_W-1:0] wstrb;
   logic [1:0]        bresp, rresp;
   logic              arvalid, arready, rvalid, rready;

   axil_cmd_initiator #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .aclk(aclk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [63:0] rdata;
      logic [1:0]  resp;
      logic        timeout;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_rsp    = 0;
   int   n_pushed = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic rsp_t mk(input logic [63:0] d, input logic [1:0] r, input logic t);
      rsp_t e;
      e.rdata   = d;
      e.resp    = r;
      e.timeout = t;
      return e;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] strb, input logic [2:0] prot,
                       input bit expect_rsp, input rsp_t e);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_wstrb = strb;
      cmd_prot  = prot;
      check("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
      if (expect_rsp) begin
         exp_q.push_back(e);
         n_pushed++;
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   // Response monitor: handshake completes at the next rising edge.
   always @(negedge aclk) begin
      if (rstn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         rsp_t e;
         n_rsp++;
         check("rsp_seq", 64'(n_rsp), 64'(n_pushed));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] held;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_prot = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1; awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = 0;
      rstn = 0;
      #1;
      tick(); tick();
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
      check("rst_readies", 64'({bready, rready}), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      rstn = 1;
      tick();
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

      // Write with an always-ready responder.
      awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
      send(1, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3'b010, 1, mk(64'h0, 2'b00, 1'b0));
      check("t1_awvalid", 64'(awvalid), 64'd1);
      check("t1_wvalid", 64'(wvalid), 64'd1);
      check("t1_awaddr", 64'(awaddr), 64'h10);
      check("t1_awprot", 64'(awprot), 64'd2);
      check("t1_wdata", wdata, 64'hDEADBEEF_CAFEF00D);
      check("t1_wstrb", 64'(wstrb), 64'hFF);
      check("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
      tick();
      check("t1_aw_w_dropped", 64'({awvalid, wvalid}), 64'd0);
      check("t1_rsp_not_yet", 64'(rsp_valid), 64'd0);
      tick();
      check("t1_rsp_at_n3", 64'(rsp_valid), 64'd1);
      bvalid = 0; awready = 0; wready = 0;
      tick();
      check("t1_rsp_done", 64'(rsp_valid), 64'd0);
      check("t1_cmd_ready_back", 64'(cmd_ready), 64'd1);

      // Write with W delayed; early bvalid must not complete the transaction.
      awready = 1; wready = 0; bvalid = 1; bresp = 2'b00;
      send(1, 32'h18, 64'h1111_2222_3333_4444, 8'h0F, 3'b000, 1, mk(64'h0, 2'b00, 1'b0));
      for (int i = 0; i < 5; i++) begin
         check("t2_wvalid_held", 64'(wvalid), 64'd1);
         check("t2_no_early_rsp", 64'(rsp_valid), 64'd0);
         tick();
      end
      wready = 1;
      tick();
      wready = 0; awready = 0;
      check("t2_wvalid_dropped", 64'(wvalid), 64'd0);
      check("t2_rsp_not_yet", 64'(rsp_valid), 64'd0);
      tick();
      check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
      bvalid = 0;
      tick();
      check("t2_cmd_ready_back", 64'(cmd_ready), 64'd1);

      // Read with SLVERR, response held while rsp_ready is low.
      arready = 1; rvalid = 1; rdata = 64'h0123_4567_89AB_CDEF; rresp = 2'b10; rsp_ready = 0;
      send(0, 32'h20, 64'h0, 8'h00, 3'b001, 1, mk(64'h0123_4567_89AB_CDEF, 2'b10, 1'b0));
      check("t3_arvalid", 64'(arvalid), 64'd1);
      check("t3_araddr", 64'(araddr), 64'h20);
      check("t3_arprot", 64'(arprot), 64'd1);
      check("t3_rready", 64'(rready), 64'd1);
      check("t3_no_awvalid", 64'(awvalid), 64'd0);
      tick();
      check("t3_arvalid_dropped", 64'(arvalid), 64'd0);
      check("t3_rsp_not_yet", 64'(rsp_valid), 64'd0);
      tick();
      rvalid = 0; arready = 0; rdata = 64'hFFFF_0000_FFFF_0000; rresp = 2'b00;
      check("t3_rsp_at_n3", 64'(rsp_valid), 64'd1);
      held = rsp_rdata;
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_valid", 64'(rsp_valid), 64'd1);
         check("t3_hold_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
         check("t3_hold_resp", 64'(rsp_resp), 64'd2);
         check("t3_hold_stable", rsp_rdata, held);
         tick();
      end
      rsp_ready = 1;
      tick();
      check("t3_rsp_done", 64'(rsp_valid), 64'd0);
      check("t3_cmd_ready_back", 64'(cmd_ready), 64'd1);

      // Read timeout: AR never accepted, then a late beat is drained and discarded.
      arready = 0; rvalid = 0;
      send(0, 32'h30, 64'h0, 8'h00, 3'b000, 1, mk(64'h0, 2'b10, 1'b1));
      for (int i = 0; i < TMO - 1; i++) begin
         check("t4_no_rsp_before_tmo", 64'(rsp_valid), 64'd0);
         tick();
      end
      tick();
      check("t4_tmo_rsp_valid", 64'(rsp_valid), 64'd1);
      check("t4_tmo_flag", 64'(rsp_timeout), 64'd1);
      check("t4_tmo_rdata", rsp_rdata, 64'h0);
      check("t4_arvalid_kept", 64'(arvalid), 64'd1);
      tick();
      check("t4_arvalid_still", 64'(arvalid), 64'd1);
      check("t4_drain_cmd_ready", 64'(cmd_ready), 64'd0);
      check("t4_rsp_consumed", 64'(rsp_valid), 64'd0);
      tick(); tick();
      arready = 1;
      tick();
      arready = 0; rvalid = 1; rdata = 64'h0BAD_0BAD_0BAD_0BAD; rresp = 2'b00;
      check("t4_cmd_ready_before_r", 64'(cmd_ready), 64'd0);
      check("t4_rready_waiting", 64'(rready), 64'd1);
      tick();
      rvalid = 0;
      check("t4_cmd_ready_after_r", 64'(cmd_ready), 64'd1);
      check("t4_no_late_rsp", 64'(rsp_valid), 64'd0);

      // Completion on the exact timeout cycle wins over the timeout.
      arready = 1; rvalid = 0;
      send(0, 32'h40, 64'h0, 8'h00, 3'b000, 1, mk(64'hA5A5_5A5A_1234_8765, 2'b00, 1'b0));
      tick();
      arready = 0;
      for (int i = 0; i < TMO - 2; i++) tick();
      check("t5_no_rsp_before", 64'(rsp_valid), 64'd0);
      rvalid = 1; rdata = 64'hA5A5_5A5A_1234_8765; rresp = 2'b00;
      tick();
      rvalid = 0;
      check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
      check("t5_not_timeout", 64'(rsp_timeout), 64'd0);
      check("t5_real_data", rsp_rdata, 64'hA5A5_5A5A_1234_8765);
      tick();
      check("t5_cmd_ready_back", 64'(cmd_ready), 64'd1);

      // Reset in the middle of a write abandons it without a response.
      awready = 0; wready = 0; bvalid = 0;
      send(1, 32'h50, 64'h5555_5555_5555_5555, 8'hFF, 3'b000, 0, mk(64'h0, 2'b00, 1'b0));
      check("t6_awvalid", 64'(awvalid), 64'd1);
      tick();
      rstn = 0;
      tick();
      check("t6_rst_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
      check("t6_rst_readies", 64'({bready, rready}), 64'd0);
      check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t6_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      rstn = 1;
      tick();
      check("t6_cmd_ready_back", 64'(cmd_ready), 64'd1);
      awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
      send(1, 32'h58, 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C, 3'b100, 1, mk(64'h0, 2'b10, 1'b0));
      check("t6_awaddr", 64'(awaddr), 64'h58);
      check("t6_wstrb", 64'(wstrb), 64'h3C);
      tick(); tick();
      check("t6_rsp_valid", 64'(rsp_valid), 64'd1);
      check("t6_rsp_resp", 64'(rsp_resp), 64'd2);
      bvalid = 0; awready = 0; wready = 0;
      tick(); tick();

      check("rsp_total", 64'(n_rsp), 64'd6);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
